// File: rtl/wb_req_queue_pkg.sv
// Shared types for the wishbone request queue: the queued request record and the issue FSM states.
package wb_req_queue_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
        logic [3:0]       we;
        logic [2:0]       naccess;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_req_queue_if.sv
// Core-side request/response and wishbone_master-side handshake bundle of the request queue.
interface wb_req_queue_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 3
);
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_data_i;
    logic [3:0]    req_we_i;
    logic [2:0]    req_naccess_i;
    logic          flush_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_data_o;
    logic          rsp_we_o;
    logic          mst_valid_o;
    logic [AW-1:0] mst_addr_o;
    logic [DW-1:0] mst_data_o;
    logic [3:0]    mst_we_o;
    logic [2:0]    mst_naccess_o;
    logic          mst_valid_i;
    logic [DW-1:0] mst_data_i;
    logic [CW-1:0] count_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_we_i, req_naccess_i, flush_i,
               mst_valid_i, mst_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_we_o,
               mst_valid_o, mst_addr_o, mst_data_o, mst_we_o, mst_naccess_o, count_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_we_i, req_naccess_i, flush_i,
               mst_valid_i, mst_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_we_o,
               mst_valid_o, mst_addr_o, mst_data_o, mst_we_o, mst_naccess_o, count_o
    );
endinterface

// File: rtl/wb_req_queue_sync_fifo.sv
// Power-of-two circular FIFO with flush; flush can optionally preserve the head entry (in-flight request).
module sync_fifo
    import wb_req_queue_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_req_t
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic                   i_flush_keep_head,
    output T                       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_rd_next;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop     = i_pop & ~o_empty;
    assign w_push    = i_push & ~o_full & ~i_flush;
    assign w_rd_next = w_pop ? r_rd_ptr + PTR_ONE : r_rd_ptr;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            // A head popped in the flush cycle is gone too, so nothing is kept.
            r_rd_ptr <= w_rd_next;
            if (i_flush_keep_head && !w_pop) begin
                r_wr_ptr <= r_rd_ptr + PTR_ONE;
                r_count  <= CNT_ONE;
            end else begin
                r_wr_ptr <= w_rd_next;
                r_count  <= '0;
            end
        end else begin
            r_rd_ptr <= w_rd_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_req_queue.sv
// Request queue in front of wishbone_master: buffers core requests, issues them one at a time,
// and returns read data as a one-cycle response pulse.
//
// state | meaning
// IDLE  | waiting for a queued request; head is loaded onto mst_* when one exists
// ISSUE | mst_valid_o high, head held in the queue until the master reports done
// GAP   | one cycle with mst_valid_o low so the master can re-arm
module wb_req_queue
    import wb_req_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    wb_req_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    we;
        logic [2:0]    naccess;
    } req_t;

    wb_state_e     r_state;
    logic          r_mst_valid;
    logic [AW-1:0] r_mst_addr;
    logic [DW-1:0] r_mst_data;
    logic [3:0]    r_mst_we;
    logic [2:0]    r_mst_naccess;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_we;

    req_t          w_in;
    req_t          w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_done;
    logic [CW-1:0] w_count;

    assign w_in = '{addr:    bus.req_addr_i,
                    data:    bus.req_data_i,
                    we:      bus.req_we_i,
                    naccess: bus.req_naccess_i};

    // Ready comes straight from the stored count: a pop in the same cycle does not free a slot yet.
    assign w_push = bus.req_valid_i & ~w_full;
    assign w_done = (r_state == ISSUE) & bus.mst_valid_i;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .i_push            (w_push),
        .i_data            (w_in),
        .i_pop             (w_done),
        .i_flush           (bus.flush_i),
        .i_flush_keep_head (r_state == ISSUE),
        .o_head            (w_head),
        .o_full            (w_full),
        .o_empty           (w_empty),
        .o_count           (w_count)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= IDLE;
            r_mst_valid   <= 1'b0;
            r_mst_addr    <= '0;
            r_mst_data    <= '0;
            r_mst_we      <= '0;
            r_mst_naccess <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_we      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A flush in this cycle empties the queue, so do not start issuing its head.
                    if (!w_empty && !bus.flush_i) begin
                        r_state       <= ISSUE;
                        r_mst_valid   <= 1'b1;
                        r_mst_addr    <= w_head.addr;
                        r_mst_data    <= w_head.data;
                        r_mst_we      <= w_head.we;
                        r_mst_naccess <= w_head.naccess;
                    end
                end
                ISSUE: begin
                    if (bus.mst_valid_i) begin
                        r_state     <= GAP;
                        r_mst_valid <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= |r_mst_we;
                        r_rsp_data  <= (r_mst_we == 4'b0000) ? bus.mst_data_i : '0;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_mst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o   = ~w_full;
    assign bus.count_o       = w_count;
    assign bus.mst_valid_o   = r_mst_valid;
    assign bus.mst_addr_o    = r_mst_addr;
    assign bus.mst_data_o    = r_mst_data;
    assign bus.mst_we_o      = r_mst_we;
    assign bus.mst_naccess_o = r_mst_naccess;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_data_o    = r_rsp_data;
    assign bus.rsp_we_o      = r_rsp_we;

endmodule
